// File: rtl/mux_lut_gate.sv
//------------------------------------------------------------------------------
// mux_lut_gate : registered per-lane mux-tree gate driven by a serially loaded
//                2^K-entry truth table; optional readback via MUX_LUT_READBACK_EN
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_lut_gate #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MUX_LUT_READBACK_EN
  output logic [(1<<K)-1:0]  table_o,
`endif
  output logic [WIDTH-1:0]   out_data
);

  localparam int T = 1 << K;
  localparam logic [T-1:0] DEFAULT_TABLE = {(T/2){2'b01}};

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t           state;
  logic [K-1:0]     cnt;
  logic [T-1:0]     staging;
  logic [T-1:0]     staging_next;
  logic [T-1:0]     lut;
  logic [WIDTH-1:0] lookup;
  logic             accept;

  assign cfg_ready = 1'b1;
  assign in_ready  = (state == RUN) && !cfg_valid && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    staging_next      = staging;
    staging_next[cnt] = cfg_bit;
  end

  // Each lane gathers its bit from every operand to form the table index.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [K-1:0] idx;
    for (genvar j = 0; j < K; j++) begin : g_op
      assign idx[j] = in_data[j*WIDTH + i];
    end
    assign lookup[i] = lut[idx];
  end

`ifdef MUX_LUT_READBACK_EN
  assign table_o = lut;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      staging   <= '0;
      lut       <= DEFAULT_TABLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cfg_valid) begin
            staging <= staging_next;
            cnt     <= K'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            staging <= staging_next;
            // Last entry commits straight from the next-staging value.
            if (cnt == K'(T-1)) begin
              lut   <= staging_next;
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase

      if (accept) begin
        out_data  <= lookup;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_lut_gate.sv
//------------------------------------------------------------------------------
// tb_mux_lut_gate : scoreboard bench for mux_lut_gate (WIDTH=8, K=2)
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_lut_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
`ifdef MUX_LUT_READBACK_EN
  logic [3:0]  table_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  mux_lut_gate #(.WIDTH(8), .K(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_LUT_READBACK_EN
    .table_o(table_o),
`endif
    .out_data(out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    logic acc;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] op0, input logic [7:0] op1, input logic [7:0] exp);
    in_data  = {op1, op0};
    in_valid = 1'b1;
    sb.push_back(exp);
    wait_accept();
  endtask

  // Loads table bits entry 0 first, idling gap cycles between bits.
  task automatic load(input logic [3:0] bits, input int gap, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[b];
      @(negedge clk);
      check("in_ready_load", {31'd0, in_ready}, 32'd0);
      check("cfg_ready", {31'd0, cfg_ready}, 32'd1);
      step();
      cfg_valid = 1'b0;
      if (b < nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("in_ready_gap", {31'd0, in_ready}, 32'd0);
          step();
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MUX_LUT_READBACK_EN
    check("rst_table", {28'd0, table_o}, 32'h5);
`endif
    step();

    // Default table: NOT of op0
    send(8'hA5, 8'h00, 8'h5A);
    send(8'h00, 8'hFF, 8'hFF);
    send(8'hFF, 8'h00, 8'h00);
    drain();

    // XOR
    load(4'b0110, 0, 4);
`ifdef MUX_LUT_READBACK_EN
    check("xor_table", {28'd0, table_o}, 32'h6);
`endif
    send(8'hF0, 8'hCC, 8'h3C);
    send(8'hAA, 8'h55, 8'hFF);
    send(8'hFF, 8'hFF, 8'h00);
    drain();

    // Backpressure (reload NOT first)
    load(4'b0101, 0, 4);
    out_ready = 1'b0;
    send(8'h0F, 8'h00, 8'hF0);
    in_data  = {8'h00, 8'hFF};
    in_valid = 1'b1;
    sb.push_back(8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {24'd0, out_data}, 32'hF0);
      step();
    end
    out_ready = 1'b1;
    wait_accept();
    drain();

    // AND fast, then XOR gapped
    load(4'b1000, 0, 4);
    send(8'hF0, 8'hCC, 8'hC0);
    drain();
    load(4'b0110, 3, 4);
    send(8'hF0, 8'hCC, 8'h3C);
    drain();

    // Collision: data offered with first cfg bit waits for the OR commit
    in_data  = {8'hCC, 8'hF0};
    in_valid = 1'b1;
    sb.push_back(8'hFC);
    load(4'b1110, 0, 4);
    wait_accept();
    drain();

    // Reset mid-load with a pending output
    out_ready = 1'b0;
    send(8'h3C, 8'h00, 8'h3C);
    load(4'b0110, 0, 2);
    rst_n = 1'b0;
    step();
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midload_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef MUX_LUT_READBACK_EN
    check("midload_table", {28'd0, table_o}, 32'h5);
`endif
    step();
    send(8'h3C, 8'h00, 8'hC3);
    drain();

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
